// File: rtl/bram_host_pkg.sv
// Shared types and sizing helpers for the BRAM host sequencer.
package bram_host_pkg;

    localparam int BramDataWidth = 64;
    localparam int MaskWidth     = BramDataWidth / 8;
    localparam int DefRespDepth  = 4;
    localparam int CntWidth      = $clog2(DefRespDepth + 1);

    // One buffered response: write acks carry zero data.
    typedef struct packed {
        logic                     write;
        logic [BramDataWidth-1:0] rdata;
    } bram_host_resp_t;

    // Occupancy counter width able to represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bram_host_resp_fifo.sv
// First-word fall-through response buffer with occupancy count for credit logic.
module bram_host_resp_fifo
    import bram_host_pkg::*;
#(
    parameter  int Width    = 65,
    parameter  int Depth    = 4,
    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW     = cnt_width(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             not_empty,
    output logic [CntW-1:0]  count
);

    localparam logic [PtrWidth-1:0] LastIdx = PtrWidth'(Depth - 1);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;

    // Pointers wrap at Depth so non-power-of-two depths work too.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == LastIdx) ? '0 : p + PtrWidth'(1);
    endfunction

    // Storage and pointer/occupancy update; storage is cleared so outputs read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data  = mem[rd_ptr];
    assign not_empty = (count != '0);

    pop_when_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));
    push_when_full: assert property (@(posedge clk) disable iff (rst)
                                     !(push && !pop && count == CntW'(Depth)));

endmodule

// File: rtl/bram_host_seq.sv
// Host side of the single-cycle BRAM register port: credit-gated command issue,
// one-cycle read capture and an in-order response buffer.
module bram_host_seq
    import bram_host_pkg::*;
#(
    parameter  int DataWidth     = BramDataWidth,
    parameter  int BramAddrWidth = 8,
    parameter  int RespDepth     = DefRespDepth,
    localparam int MaskW         = DataWidth / 8,
    localparam int CntW          = cnt_width(RespDepth)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_write_i,
    input  logic [BramAddrWidth-1:0] cmd_addr_i,
    input  logic [DataWidth-1:0]     cmd_wdata_i,
    input  logic [MaskW-1:0]         cmd_wmask_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic                     resp_write_o,
    output logic [DataWidth-1:0]     resp_rdata_o,
    output logic                     bram_en_o,
    output logic                     bram_we_o,
    output logic [MaskW-1:0]         bram_wmask_o,
    output logic [BramAddrWidth-1:0] bram_addr_o,
    output logic [DataWidth-1:0]     bram_wdata_o,
    input  logic [DataWidth-1:0]     bram_rdata_i
);

    logic             fire;
    logic             pending;
    logic             pending_write;
    logic             pop;
    logic             not_empty;
    logic [CntW-1:0]  count;
    logic [CntW:0]    used;
    logic [DataWidth:0] push_data;
    logic [DataWidth:0] pop_data;

    // A credit is held from fire until the response leaves the buffer; pops only
    // return credit through the registered count, so ready never depends on resp_ready_i.
    assign used        = {1'b0, count} + (CntW + 1)'(pending);
    assign cmd_ready_o = !rst_i && (used < (CntW + 1)'(RespDepth));
    assign fire        = cmd_valid_i && cmd_ready_o;

    // Device strobe is driven straight from the accepted command; idle port is all zeros.
    always_comb begin
        bram_en_o    = 1'b0;
        bram_we_o    = 1'b0;
        bram_wmask_o = '0;
        bram_addr_o  = '0;
        bram_wdata_o = '0;
        if (fire) begin
            bram_en_o    = 1'b1;
            bram_we_o    = cmd_write_i;
            bram_wmask_o = cmd_write_i ? cmd_wmask_i : '0;
            bram_addr_o  = cmd_addr_i;
            bram_wdata_o = cmd_wdata_i;
        end
    end

    // Remember that an access is in flight so its result is captured next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending       <= 1'b0;
            pending_write <= 1'b0;
        end else begin
            pending <= fire;
            if (fire) begin
                pending_write <= cmd_write_i;
            end
        end
    end

    assign push_data = {pending_write, pending_write ? {DataWidth{1'b0}} : bram_rdata_i};
    assign pop       = resp_valid_o && resp_ready_i;

    bram_host_resp_fifo #(
        .Width (DataWidth + 1),
        .Depth (RespDepth)
    ) u_resp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (pending),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .not_empty (not_empty),
        .count     (count)
    );

    assign resp_valid_o = not_empty;
    assign resp_write_o = pop_data[DataWidth];
    assign resp_rdata_o = pop_data[DataWidth-1:0];

endmodule

// File: tb/tb_bram_host_seq.sv
// Scoreboard bench for bram_host_seq driving a one-cycle registered 256x64 device model.
module tb_bram_host_seq;
    import bram_host_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [7:0]  cmd_addr_i;
    logic [63:0] cmd_wdata_i;
    logic [7:0]  cmd_wmask_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic        resp_write_o;
    logic [63:0] resp_rdata_o;
    logic        bram_en_o;
    logic        bram_we_o;
    logic [7:0]  bram_wmask_o;
    logic [7:0]  bram_addr_o;
    logic [63:0] bram_wdata_o;
    logic [63:0] bram_rdata_i;

    int checks;
    int failures;
    int cycle;
    int fire_count;
    int resp_count;
    int fire_cycles[$];
    int resp_cycles[$];
    bram_host_resp_t exp_q[$];
    logic [63:0] ref_mem [int];
    logic [63:0] last_rdata;
    bit dev_loaded;
    logic [63:0] dev_mem [256];

    bram_host_seq #(
        .DataWidth     (64),
        .BramAddrWidth (8),
        .RespDepth     (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .cmd_wmask_i  (cmd_wmask_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_write_o (resp_write_o),
        .resp_rdata_o (resp_rdata_o),
        .bram_en_o    (bram_en_o),
        .bram_we_o    (bram_we_o),
        .bram_wmask_o (bram_wmask_o),
        .bram_addr_o  (bram_addr_o),
        .bram_wdata_o (bram_wdata_o),
        .bram_rdata_i (bram_rdata_i)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Cycle counter used to time fires against responses.
    always @(posedge clk_i) cycle <= cycle + 1;

    // Power-on contents: a recognisable pattern, with word 5 left at zero.
    function automatic logic [63:0] init_word(input int i);
        if (i == 5) return 64'h0;
        return {32'hC0DE_5EED, 24'h0, 8'(i)};
    endfunction

    function automatic logic [63:0] ref_read(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // One-cycle registered device: byte-masked writes, read data valid the next cycle.
    always @(posedge clk_i) begin
        if (!dev_loaded) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
            dev_loaded <= 1'b1;
        end else if (bram_en_o) begin
            if (bram_we_o) begin
                for (int b = 0; b < 8; b++)
                    if (bram_wmask_o[b]) dev_mem[bram_addr_o][8*b +: 8] <= bram_wdata_o[8*b +: 8];
            end else begin
                bram_rdata_i <= dev_mem[bram_addr_o];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Watches every falling edge: predicts responses at fire, checks the device drive,
    // compares popped responses and checks response stability under backpressure.
    task automatic monitor();
        bit              hold_valid = 1'b0;
        logic            hold_write = 1'b0;
        logic [63:0]     hold_rdata = '0;
        logic [63:0]     word;
        bram_host_resp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                exp_q.delete();
                hold_valid = 1'b0;
                checkOutput("reset_outputs",
                    {cmd_ready_o, resp_valid_o, resp_write_o, resp_rdata_o,
                     bram_en_o, bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o}, '0);
            end else begin
                if (hold_valid)
                    checkOutput("resp_stable", {resp_valid_o, resp_write_o, resp_rdata_o},
                                {1'b1, hold_write, hold_rdata});
                if (cmd_valid_i && cmd_ready_o) begin
                    fire_count++;
                    fire_cycles.push_back(cycle);
                    checkOutput("bram_drive",
                        {bram_en_o, bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o},
                        {1'b1, cmd_write_i, cmd_write_i ? cmd_wmask_i : 8'h00, cmd_addr_i, cmd_wdata_i});
                    if (cmd_write_i) begin
                        word = ref_read(int'(cmd_addr_i));
                        for (int b = 0; b < 8; b++)
                            if (cmd_wmask_i[b]) word[8*b +: 8] = cmd_wdata_i[8*b +: 8];
                        ref_mem[int'(cmd_addr_i)] = word;
                        e.write = 1'b1;
                        e.rdata = '0;
                    end else begin
                        e.write = 1'b0;
                        e.rdata = ref_read(int'(cmd_addr_i));
                    end
                    exp_q.push_back(e);
                end else begin
                    checkOutput("bram_idle",
                        {bram_en_o, bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o}, '0);
                end
                if (resp_valid_o && resp_ready_i) begin
                    resp_count++;
                    resp_cycles.push_back(cycle);
                    if (exp_q.size() == 0) begin
                        checkOutput("resp_unexpected", resp_valid_o, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("resp_data", {resp_write_o, resp_rdata_o}, {e.write, e.rdata});
                        last_rdata = resp_rdata_o;
                    end
                end
                hold_valid = resp_valid_o && !resp_ready_i;
                hold_write = resp_write_o;
                hold_rdata = resp_rdata_o;
            end
        end
    endtask

    // Presents one command and returns just after the edge on which it fired.
    task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [63:0] d, input logic [7:0] m);
        int waited = 0;
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_wmask_i = m;
        @(negedge clk_i);
        while (!cmd_ready_o && waited < 100) begin
            waited++;
            @(negedge clk_i);
        end
        if (!cmd_ready_o) checkOutput("cmd_timeout", cmd_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_wmask_i = '0;
    endtask

    task automatic waitDrain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 300) begin
            @(posedge clk_i);
            budget++;
        end
        #1;
        checkOutput("drain", exp_q.size(), 0);
    endtask

    // Directed sequence followed by a randomised soak.
    initial begin
        int base_f;
        int base_r;
        int fires_before;
        int resps_before;

        rst_i        = 1'b1;
        resp_ready_i = 1'b0;
        idle();
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_state",
            {cmd_ready_o, resp_valid_o, resp_write_o, resp_rdata_o, bram_en_o, bram_we_o},
            '0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("ready_after_reset", cmd_ready_o, 1'b1);
        @(posedge clk_i);
        #1;

        // Full-mask write then read back.
        resp_ready_i = 1'b1;
        applyStimulus(1'b1, 8'h00, 64'h1234, 8'hFF);
        applyStimulus(1'b0, 8'h00, 64'h0, 8'h00);
        idle();
        waitDrain();
        checkOutput("t1_read_back", last_rdata, 64'h1234);

        // Partial-mask write over a zero word.
        applyStimulus(1'b1, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 8'h03);
        applyStimulus(1'b0, 8'h05, 64'h0, 8'h00);
        idle();
        waitDrain();
        checkOutput("t2_masked_read", last_rdata, 64'h0000_0000_0000_FFFF);

        // Backpressure: credits stop issue after four commands.
        resp_ready_i = 1'b0;
        fires_before = fire_count;
        cmd_valid_i  = 1'b1;
        cmd_write_i  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cmd_addr_i = 8'(16 + i);
            @(posedge clk_i);
            #1;
        end
        checkOutput("t3_fire_count", fire_count - fires_before, 4);
        checkOutput("t3_ready_stalled", cmd_ready_o, 1'b0);
        checkOutput("t3_resp_held", resp_valid_o, 1'b1);
        idle();
        resps_before = resp_count;
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t3_ready_during_pop", cmd_ready_o, 1'b0);
        @(negedge clk_i);
        checkOutput("t3_ready_after_pop", cmd_ready_o, 1'b1);
        waitDrain();
        checkOutput("t3_resp_count", resp_count - resps_before, 4);

        // Streaming reads at full rate.
        base_f = fire_cycles.size();
        base_r = resp_cycles.size();
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'(i), 64'h0, 8'h00);
        idle();
        waitDrain();
        checkOutput("t4_fires", fire_cycles.size() - base_f, 16);
        checkOutput("t4_fire_span", fire_cycles[base_f + 15] - fire_cycles[base_f], 15);
        checkOutput("t4_first_latency", resp_cycles[base_r] - fire_cycles[base_f], 2);
        checkOutput("t4_last_rdata", last_rdata, {32'hC0DE_5EED, 24'h0, 8'd15});

        // Reset in the capture cycle drops the pending read.
        applyStimulus(1'b0, 8'h03, 64'h0, 8'h00);
        rst_i = 1'b1;
        idle();
        #1;
        checkOutput("t5_reset_outputs",
            {cmd_ready_o, resp_valid_o, resp_write_o, resp_rdata_o,
             bram_en_o, bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o}, '0);
        resps_before = resp_count;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        checkOutput("t5_no_response", resp_count - resps_before, 0);
        checkOutput("t5_resp_valid", resp_valid_o, 1'b0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 10000; i++) begin
            cmd_valid_i  = 1'($urandom_range(0, 1));
            cmd_write_i  = 1'($urandom_range(0, 1));
            cmd_addr_i   = 8'($urandom_range(0, 31));
            cmd_wdata_i  = {$urandom, $urandom};
            cmd_wmask_i  = 8'($urandom);
            resp_ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk_i);
            #1;
        end
        idle();
        resp_ready_i = 1'b1;
        waitDrain();
        checkOutput("t6_balance", fire_count - resp_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
